// File: rtl/ddr_write_scheduler_if.sv
// Byte-FIFO read port and line-write command/response channel of the DDR write scheduler.
// The master side is the scheduler; the slave side is the FIFO plus the memory controller.
interface ddr_write_scheduler_if #(
  parameter int ADDR_W = 28
);
  logic              fifo_empty;
  logic              read_en;
  logic [7:0]        i_data;
  logic              i_flush;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [255:0]      wr_data;
  logic              wr_resp_valid;

  modport master (
    input  fifo_empty, i_data, i_flush, wr_ready, wr_resp_valid,
    output read_en, wr_valid, wr_addr, wr_data
  );

  modport slave (
    output fifo_empty, i_data, i_flush, wr_ready, wr_resp_valid,
    input  read_en, wr_valid, wr_addr, wr_data
  );
endinterface

// File: rtl/ddr_write_scheduler.sv
// Packs bytes from a FIFO into 32-byte lines and issues each line as one memory write,
// waiting for a completion pulse (or a timeout) before starting the next line.
module ddr_write_scheduler #(
  parameter int                ADDR_W       = 28,
  parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
  parameter int                NUM_LINES    = 16,
  parameter int                RESP_TIMEOUT = 255
) (
  input  logic                  axi_clk,
  input  logic                  rst,
  ddr_write_scheduler_if.master bus,
  output logic [15:0]           line_count,
  output logic                  wrap_pulse,
  output logic                  err_timeout,
  output logic                  busy
);

  typedef enum logic [1:0] {FETCH, CAPTURE, ISSUE, RESP} state_t;

  state_t       state;
  state_t       state_d;
  logic [4:0]   byte_cnt;
  logic [15:0]  line_idx;
  logic [15:0]  resp_timer;
  logic [255:0] line_buf;
  logic         capture_en;
  logic         flush_go;
  logic         accept;
  logic         resp_hit;
  logic         timeout_hit;
  logic         line_done;

  always_ff @(posedge axi_clk) begin
    if (rst) state <= FETCH;
    else     state <= state_d;
  end

  always_comb begin
    state_d      = state;
    bus.read_en  = 1'b0;
    bus.wr_valid = 1'b0;
    capture_en   = 1'b0;
    flush_go     = 1'b0;
    accept       = 1'b0;
    resp_hit     = 1'b0;
    timeout_hit  = 1'b0;
    case (state)
      FETCH: begin
        // A pending byte always beats a flush request.
        if (!bus.fifo_empty) begin
          bus.read_en = !rst;
          state_d     = CAPTURE;
        end else if (bus.i_flush && byte_cnt != 5'd0) begin
          flush_go = 1'b1;
          state_d  = ISSUE;
        end
      end
      CAPTURE: begin
        capture_en = 1'b1;
        state_d    = (byte_cnt == 5'd31) ? ISSUE : FETCH;
      end
      ISSUE: begin
        bus.wr_valid = 1'b1;
        if (bus.wr_ready) begin
          accept  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.wr_resp_valid) begin
          resp_hit = 1'b1;
          state_d  = FETCH;
        end else if (resp_timer == 16'(RESP_TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          state_d     = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  assign line_done = resp_hit | timeout_hit;

  always_ff @(posedge axi_clk) begin
    if (rst) begin
      byte_cnt    <= '0;
      line_idx    <= '0;
      line_count  <= '0;
      resp_timer  <= '0;
      line_buf    <= '0;
      wrap_pulse  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      wrap_pulse <= 1'b0;
      // byte_cnt rolls from 31 to 0 on the last capture of a full line.
      if (capture_en) begin
        line_buf[{byte_cnt, 3'b000} +: 8] <= bus.i_data;
        byte_cnt                          <= byte_cnt + 5'd1;
      end
      if (flush_go) byte_cnt <= '0;
      // Clearing the buffer once a line is accepted makes a later flush zero-padded.
      if (accept) begin
        resp_timer <= '0;
        line_buf   <= '0;
      end
      if (state == RESP && !line_done) resp_timer <= resp_timer + 16'd1;
      if (line_done) begin
        line_count <= line_count + 16'd1;
        if (line_idx == 16'(NUM_LINES - 1)) begin
          line_idx   <= '0;
          wrap_pulse <= 1'b1;
        end else begin
          line_idx <= line_idx + 16'd1;
        end
      end
      if (timeout_hit) err_timeout <= 1'b1;
    end
  end

  assign bus.wr_addr = BASE_ADDR + ADDR_W'({line_idx, 5'b00000});
  assign bus.wr_data = line_buf;
  assign busy        = !(state == FETCH && byte_cnt == 5'd0);

endmodule

// File: tb/tb_ddr_write_scheduler.sv
// Directed bench for ddr_write_scheduler: full lines, flush, stalled issue, response/timeout,
// line-index wrap and mid-line reset, with a small byte FIFO model driving the read port.
module tb_ddr_write_scheduler;

  logic        axi_clk = 1'b0;
  logic        rst;
  logic [15:0] line_count;
  logic        wrap_pulse;
  logic        err_timeout;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int wrap_cnt = 0;

  logic [7:0] fifo_mem [256];
  int pushed = 0;
  int popped = 0;

  ddr_write_scheduler_if #(.ADDR_W(28)) bus ();

  ddr_write_scheduler #(
    .ADDR_W(28), .BASE_ADDR(28'h0), .NUM_LINES(4), .RESP_TIMEOUT(8)
  ) dut (
    .axi_clk    (axi_clk),
    .rst        (rst),
    .bus        (bus),
    .line_count (line_count),
    .wrap_pulse (wrap_pulse),
    .err_timeout(err_timeout),
    .busy       (busy)
  );

  always #5 axi_clk = ~axi_clk;

  assign bus.fifo_empty = (pushed == popped);

  always @(posedge axi_clk) begin
    if (bus.read_en && pushed != popped) begin
      bus.i_data <= fifo_mem[popped & 255];
      popped     <= popped + 1;
    end
  end

  always @(posedge axi_clk) if (wrap_pulse) wrap_cnt <= wrap_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench watchdog expired");
  end

  task automatic chk(input string tag, input logic [299:0] obs, input logic [299:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo_mem[pushed & 255] = b;
    pushed++;
  endtask

  // Sends one line of nb bytes starting at b0 (flushing if short) and answers it in RESP
  // cycle resp_cyc, or lets it time out when resp_cyc is 0.
  task automatic do_line(input int nb, input logic [7:0] b0, input logic [27:0] ea,
                         input int resp_cyc, input logic [15:0] exp_lc);
    logic [255:0] ed;
    int cyc;
    ed = '0;
    for (int k = 0; k < nb; k++) begin
      ed[8*k +: 8] = b0 + 8'(k);
      push(b0 + 8'(k));
    end
    cyc = 0;
    if (nb < 32) begin
      repeat (2 * nb + 2) @(negedge axi_clk);
      bus.i_flush = 1'b1;
    end
    while (!bus.wr_valid && cyc < 200) begin
      @(negedge axi_clk);
      cyc++;
    end
    bus.i_flush = 1'b0;
    chk("wr_valid_seen", 300'(bus.wr_valid), 300'(1));
    if (nb == 32) chk("full_line_latency", 300'(cyc), 300'(64));
    chk("wr_addr", 300'(bus.wr_addr), 300'(ea));
    chk("wr_data", 300'(bus.wr_data), 300'(ed));
    @(negedge axi_clk);
    chk("wr_valid_after_accept", 300'(bus.wr_valid), 300'(0));
    if (resp_cyc > 0) begin
      repeat (resp_cyc - 1) @(negedge axi_clk);
      bus.wr_resp_valid = 1'b1;
      @(negedge axi_clk);
      bus.wr_resp_valid = 1'b0;
    end else begin
      repeat (6) @(negedge axi_clk);
      chk("err_before_expiry", 300'(err_timeout), 300'(0));
      repeat (2) @(negedge axi_clk);
    end
    chk("line_count", 300'(line_count), 300'(exp_lc));
    chk("busy_idle", 300'(busy), 300'(0));
  endtask

  initial begin
    logic [255:0] ed;
    rst               = 1'b1;
    bus.i_flush       = 1'b0;
    bus.wr_ready      = 1'b1;
    bus.wr_resp_valid = 1'b0;
    bus.i_data        = 8'h00;
    repeat (3) @(negedge axi_clk);
    chk("rst_read_en", 300'(bus.read_en), 300'(0));
    chk("rst_wr_valid", 300'(bus.wr_valid), 300'(0));
    chk("rst_busy", 300'(busy), 300'(0));
    chk("rst_wr_data", 300'(bus.wr_data), 300'(0));
    chk("rst_wr_addr", 300'(bus.wr_addr), 300'(0));
    chk("rst_line_count", 300'(line_count), 300'(0));
    chk("rst_err_wrap", 300'({err_timeout, wrap_pulse}), 300'(0));
    rst = 1'b0;
    @(negedge axi_clk);

    // Full line 0x00..0x1F, response in RESP cycle 3.
    do_line(32, 8'h00, 28'h000_0000, 3, 16'd1);
    chk("addr_next_line", 300'(bus.wr_addr), 300'(28'h20));

    // Stray response outside RESP must be ignored.
    bus.wr_resp_valid = 1'b1;
    @(negedge axi_clk);
    bus.wr_resp_valid = 1'b0;
    @(negedge axi_clk);
    chk("stray_resp_ignored", 300'(line_count), 300'(1));

    // Partial line kept across idle, flushed while the memory side stalls for 10+ cycles.
    ed = '0;
    for (int k = 0; k < 5; k++) begin
      ed[8*k +: 8] = 8'hA1 + 8'(k);
      push(8'hA1 + 8'(k));
    end
    repeat (12) @(negedge axi_clk);
    chk("partial_busy", 300'(busy), 300'(1));
    repeat (30) @(negedge axi_clk);
    chk("idle_hold", 300'({busy, bus.wr_valid, bus.read_en}), 300'(3'b100));
    bus.wr_ready = 1'b0;
    bus.i_flush  = 1'b1;
    @(negedge axi_clk);
    bus.i_flush  = 1'b0;
    chk("flush_wr_data", 300'(bus.wr_data), 300'(ed));
    for (int i = 0; i < 10; i++) begin
      @(negedge axi_clk);
      chk("stall_stable", 300'({bus.wr_valid, bus.wr_addr, bus.wr_data}),
          300'({1'b1, 28'h20, ed}));
    end
    bus.wr_ready = 1'b1;
    @(negedge axi_clk);
    chk("stall_accepted", 300'(bus.wr_valid), 300'(0));
    // Response lands in the same cycle the timeout would expire.
    repeat (7) @(negedge axi_clk);
    bus.wr_resp_valid = 1'b1;
    @(negedge axi_clk);
    bus.wr_resp_valid = 1'b0;
    chk("collision_count", 300'(line_count), 300'(2));
    chk("collision_no_err", 300'(err_timeout), 300'(0));

    // No response: timeout after 8 RESP cycles, line still retired.
    do_line(8, 8'h10, 28'h40, 0, 16'd3);
    chk("err_timeout_set", 300'(err_timeout), 300'(1));
    chk("addr_after_timeout", 300'(bus.wr_addr), 300'(28'h60));
    chk("no_wrap_yet", 300'(wrap_cnt), 300'(0));

    // Fourth line wraps the line index.
    do_line(32, 8'h80, 28'h60, 1, 16'd4);
    chk("wrap_pulse_high", 300'(wrap_pulse), 300'(1));
    chk("addr_wrapped", 300'(bus.wr_addr), 300'(28'h0));
    @(negedge axi_clk);
    chk("wrap_pulse_low", 300'(wrap_pulse), 300'(0));
    chk("err_sticky", 300'(err_timeout), 300'(1));
    do_line(7, 8'hC0, 28'h0, 2, 16'd5);
    chk("wrap_count", 300'(wrap_cnt), 300'(1));

    // Reset after 17 captured bytes abandons the line.
    for (int k = 0; k < 17; k++) push(8'h55 + 8'(k));
    repeat (40) @(negedge axi_clk);
    chk("mid_line_busy", 300'(busy), 300'(1));
    rst = 1'b1;
    @(negedge axi_clk);
    chk("mid_rst_outputs", 300'({bus.read_en, bus.wr_valid, busy, wrap_pulse, err_timeout}),
        300'(0));
    chk("mid_rst_data", 300'(bus.wr_data), 300'(0));
    chk("mid_rst_addr_count", 300'({bus.wr_addr, line_count}), 300'(0));
    rst = 1'b0;
    @(negedge axi_clk);
    chk("post_rst_no_valid", 300'(bus.wr_valid), 300'(0));
    do_line(32, 8'h60, 28'h0, 2, 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr_write_scheduler.md
DDR_WRITE_SCHEDULER -- requirements
Module: ddr_write_scheduler

Interface
REQ-001 Parameter ADDR_W, default 28, memory byte-address width.
REQ-002 Parameter BASE_ADDR, default 0, byte address of line 0; 32-byte aligned.
REQ-003 Parameter NUM_LINES, default 16, lines before address wrap; range 1..65535.
REQ-004 Parameter RESP_TIMEOUT, default 255, cycles to wait for write response; range 1..65535.
REQ-005 axi_clk  in  1  sole clock; all logic on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 fifo_empty  in  1  byte FIFO empty flag.
REQ-008 read_en  out  1  byte FIFO read strobe, one cycle per byte.
REQ-009 i_data  in  8  FIFO read data; valid the cycle after read_en.
REQ-010 i_flush  in  1  level request to emit a partial line zero-padded.
REQ-011 wr_valid  out  1  write command valid.
REQ-012 wr_ready  in  1  memory side accepts command.
REQ-013 wr_addr  out  ADDR_W  line byte address.
REQ-014 wr_data  out  256  line payload.
REQ-015 wr_resp_valid  in  1  one-cycle write completion pulse.
REQ-016 line_count  out  16  lines completed, modulo 2^16.
REQ-017 wrap_pulse  out  1  one-cycle pulse when the line index wraps to 0.
REQ-018 err_timeout  out  1  sticky response-timeout flag.
REQ-019 busy  out  1  high unless in FETCH with zero bytes buffered.

Function
REQ-020 States: FETCH, CAPTURE, ISSUE, RESP; reset state FETCH.
REQ-021 FETCH, fifo_empty=0: read_en=1 for that cycle -> CAPTURE.
REQ-022 FETCH, fifo_empty=1, i_flush=1, byte_cnt>0: remaining bytes zero-filled -> ISSUE, no read_en.
REQ-023 FETCH, fifo_empty=1, i_flush=1, byte_cnt=0: no action, remain in FETCH.
REQ-024 FETCH, fifo_empty=0 with i_flush=1: the read takes priority; flush is honoured only once the FIFO is empty.
REQ-025 read_en is never asserted outside FETCH, nor when fifo_empty=1.
REQ-026 CAPTURE: i_data stored at bits [8k+7:8k], k=byte_cnt (first byte in [7:0]); byte_cnt increments.
REQ-027 CAPTURE, k=31 -> ISSUE, byte_cnt cleared; otherwise -> FETCH.
REQ-028 Throughput: 2 cycles per byte; the first wr_valid follows the 32nd capture by 1 cycle.
REQ-029 ISSUE: wr_valid=1; wr_addr and wr_data held stable until wr_ready=1 in the same cycle as wr_valid=1.
REQ-030 ISSUE, handshake -> RESP next cycle, wr_valid=0, timeout counter cleared.
REQ-031 wr_addr = BASE_ADDR + 32*line_idx, truncated to ADDR_W.
REQ-032 RESP, wr_resp_valid=1: line_count+1, line_idx advances -> FETCH.
REQ-033 RESP, counter reaches RESP_TIMEOUT with no response: err_timeout=1 (sticky), line_count+1, line_idx advances -> FETCH.
REQ-034 Response and timeout expiry in the same cycle: the response wins and err_timeout is unchanged.
REQ-035 wr_resp_valid outside RESP is ignored.
REQ-036 line_idx = NUM_LINES-1 advancing: line_idx becomes 0 and wrap_pulse=1 for exactly that cycle.
REQ-037 line_count wraps from 65535 to 0 with no flag.
REQ-038 A partially filled line keeps its bytes across idle periods of any length.

Reset
REQ-039 rst=1 at a clock edge: state=FETCH, byte_cnt=0, line_idx=0, line_count=0, timeout counter=0.
REQ-040 rst=1 at a clock edge: read_en=0, wr_valid=0, wrap_pulse=0, err_timeout=0, busy=0, wr_data=0, wr_addr=BASE_ADDR.
REQ-041 rst asserted mid-line or mid-handshake abandons that line; no wr_valid in the cycle after rst.

Verification
REQ-042 32 bytes 0x00..0x1F, wr_ready=1, resp 3 cycles later -> one write: addr 0, data byte k=k, line_count=1.
REQ-043 5 bytes 0xA1..0xA5, then FIFO empty, i_flush=1 -> write with bytes 0..4=A1..A5, rest 0x00.
REQ-044 wr_ready low 10 cycles during ISSUE -> wr_valid high throughout; addr and data unchanged until accept.
REQ-045 NUM_LINES=4, send 5 lines -> addrs 0,0x20,0x40,0x60,0x00; wrap_pulse once, after the 4th line.
REQ-046 RESP_TIMEOUT=8, no response -> err_timeout=1 at cycle 8 of RESP; next line still issued at 0x20.
REQ-047 rst pulse after 17 bytes captured -> all outputs at reset values; next 32 bytes form a line at addr 0.
